// File: rtl/button_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, counter-based stability filter and
// a four-state FSM producing a clean level, press/release pulses, an LED toggle and a press count.
module button_debouncer #(
    parameter int unsigned CNT_WIDTH       = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       led,
    output logic [7:0] press_count
);

    localparam int unsigned          COUNT_W  = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    logic                 ff1_q;
    logic                 ff2_q;
    logic                 s_c;
    state_e               state_q,   state_d;
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic                 level_q,   level_d;
    logic                 press_q,   press_d;
    logic                 release_q, release_d;
    logic                 led_q,     led_d;
    logic [COUNT_W-1:0]   count_q,   count_d;

    // Raw pin is synchronized; the reset value is the idle (released) pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= ACTIVE_LOW;
            ff2_q <= ACTIVE_LOW;
        end else begin
            ff1_q <= btn;
            ff2_q <= ff1_q;
        end
    end

    // Normalized synchronized sample: 1 = pressed.
    assign s_c = ff2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            led_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            led_q     <= led_d;
            count_q   <= count_d;
        end
    end

    // Any opposite sample in a WAIT state drops back to the stable state with no credit kept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        led_d     = led_q;
        count_d   = count_q;
        case (state_q)
            RELEASED: begin
                if (s_c) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!s_c) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    led_d   = ~led_q;
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_c) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (s_c) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign led           = led_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, active-low key, 20 ns clock.
module tb_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       led;
    logic [7:0] press_count;

    int checks;
    int errors;

    button_debouncer #(
        .CNT_WIDTH      (20),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .led          (led),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance past the next rising edge and sit 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b1;
        repeat (3) step();
        #4 rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if ({btn_level, press_pulse, release_pulse, led} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000", {btn_level, press_pulse, release_pulse, led});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", press_count);
        end
    endtask

    task automatic test_bounce_reject();
        int pulses;
        pulses = 0;
        btn = 1'b0; repeat (3) step();
        btn = 1'b1; step();
        btn = 1'b0; repeat (2) step();
        btn = 1'b1;
        repeat (20) begin
            if (press_pulse === 1'b1 || btn_level !== 1'b0) pulses++;
            step();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL bounce_reject_activity: got %0d cycles with pulse/level required 0", pulses);
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL bounce_reject_count: got %0d required 0", press_count);
        end
    endtask

    task automatic test_clean_press();
        int extra;
        btn = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            step();
            checks++;
            if (press_pulse !== (e == 5)) begin
                errors++;
                $display("FAIL clean_press_pulse edge %0d: got %b required %b", e, press_pulse, (e == 5));
            end
            checks++;
            if (btn_level !== (e >= 5)) begin
                errors++;
                $display("FAIL clean_press_level edge %0d: got %b required %b", e, btn_level, (e >= 5));
            end
        end
        checks++;
        if (led !== 1'b1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL clean_press_led_count: got led=%b count=%0d required led=1 count=1", led, press_count);
        end
        extra = 0;
        repeat (50) begin
            step();
            if (press_pulse === 1'b1 || release_pulse === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL held_no_repeat: got %0d pulses required 0", extra);
        end
    endtask

    task automatic test_bounce_settle();
        int early;
        early = 0;
        btn = 1'b1; step();
        if (release_pulse === 1'b1) early++;
        btn = 1'b0; step();
        if (release_pulse === 1'b1) early++;
        btn = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            if (e < 5 && release_pulse === 1'b1) early++;
            checks++;
            if (release_pulse !== (e == 5)) begin
                errors++;
                $display("FAIL settle_release_pulse edge %0d: got %b required %b", e, release_pulse, (e == 5));
            end
            checks++;
            if (btn_level !== (e < 5)) begin
                errors++;
                $display("FAIL settle_level edge %0d: got %b required %b", e, btn_level, (e < 5));
            end
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL settle_early_release: got %0d required 0", early);
        end
        checks++;
        if (led !== 1'b1 || press_count !== 8'd1 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL settle_led_count: got led=%b count=%0d pp=%b required led=1 count=1 pp=0",
                     led, press_count, press_pulse);
        end
    endtask

    task automatic test_async_reset();
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, led} !== 4'b0000 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got lvl=%b pp=%b rp=%b led=%b count=%0d required all 0",
                     btn_level, press_pulse, release_pulse, led, press_count);
        end
        repeat (2) step();
        #4 rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        int np;
        int nr;
        int both;
        np = 0; nr = 0; both = 0;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b0;
            repeat (8) begin
                step();
                if (press_pulse === 1'b1) np++;
                if (release_pulse === 1'b1) nr++;
                if (press_pulse === 1'b1 && release_pulse === 1'b1) both++;
            end
            if (i == 254) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_count_255: got %0d required 255", press_count);
                end
            end
            btn = 1'b1;
            repeat (8) begin
                step();
                if (press_pulse === 1'b1) np++;
                if (release_pulse === 1'b1) nr++;
                if (press_pulse === 1'b1 && release_pulse === 1'b1) both++;
            end
        end
        checks++;
        if (press_count !== 8'd0 || led !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final: got count=%0d led=%b required count=0 led=0", press_count, led);
        end
        checks++;
        if (np !== 256 || nr !== 256 || both !== 0) begin
            errors++;
            $display("FAIL wrap_pulses: got press=%0d release=%0d both=%0d required 256 256 0", np, nr, both);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int pre;
        pre = 0;
        btn = 1'b0;
        repeat (4) begin
            step();
            if (press_pulse === 1'b1) pre++;
        end
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if (pre !== 0 || press_pulse !== 1'b0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL mid_debounce_abort: got pre=%0d pp=%b lvl=%b required 0 0 0", pre, press_pulse, btn_level);
        end
        #4 rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            step();
            checks++;
            if (press_pulse !== (e == 5)) begin
                errors++;
                $display("FAIL post_reset_pulse edge %0d: got %b required %b", e, press_pulse, (e == 5));
            end
        end
        checks++;
        if (press_count !== 8'd1 || led !== 1'b1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_state: got count=%0d led=%b lvl=%b required 1 1 1", press_count, led, btn_level);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn    = 1'b1;
        test_reset();
        test_bounce_reject();
        test_clean_press();
        test_bounce_settle();
        test_async_reset();
        test_wrap();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
